serial_and_16: RTL and testbench



---
 rtl/serial_and_16_pkg.sv | 13 +
 rtl/serial_and_16_and_0.sv | 10 +
 rtl/serial_and_16.sv | 112 +++++++++++
 tb/tb_serial_and_16.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_and_16_pkg.sv
// Shared definitions for the bit-serial word AND: FSM state encoding and default width.
package serial_and_16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_and_16_and_0.sv
// Single 1-bit AND gate, reused once per clock as the serial compute element.
module and_0 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a & b;

endmodule

// File: rtl/serial_and_16.sv
// Bit-serial word AND: accepts an operand pair, ANDs one bit per clock LSB first
// through one shared gate, then offers the result over a valid/ready handshake.
module serial_and_16
    import serial_and_16_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             bit_and;
    logic [WIDTH-1:0] res_shifted;

    and_0 u_and_0 (
        .a (a_sr_q[0]),
        .b (b_sr_q[0]),
        .y (bit_and)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 lands at index 0.
    assign res_shifted = {bit_and, res_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        out_d    = out_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    res_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                res_sr_d = res_shifted;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    out_d   = res_shifted;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_SHIFT) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            res_sr_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            res_sr_q    <= res_sr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_and_16.sv
// Self-checking bench for serial_and_16: directed scenarios plus randomized traffic
// against a cycle-count model of the accept/compute/deliver protocol.
module tb_serial_and_16;

    localparam int W = 16;
    localparam int LAT = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         busy;

    int vectors;
    int miscompares;
    int cyc;

    serial_and_16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) step();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL go_idle: in_ready=%b required 1 within 40 cycles", in_ready);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        step();
        step();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out=%h required 1 0 0 0000",
                     in_ready, out_valid, busy, out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        $display("reset: in_ready=%b out_valid=%b busy=%b out=%h", in_ready, out_valid, busy, out);
    endtask

    task automatic test_latency();
        in_valid  = 1'b1;
        a         = 16'hFFFF;
        b         = 16'h0F0F;
        out_ready = 1'b1;
        step();  // E0
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_accept: busy=%b in_ready=%b required 1 0", busy, in_ready);
        end
        for (int i = 1; i <= LAT; i++) begin
            step();
            vectors++;
            if (out_valid !== (i == LAT) || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL latency_E%0d: out_valid=%b busy=%b required %b 1",
                         i, out_valid, busy, (i == LAT));
            end
        end
        vectors++;
        if (out !== 16'h0F0F) begin
            miscompares++;
            $display("FAIL latency_out: out=%h required 0f0f", out);
        end
        step();  // E17 handshake
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out !== 16'h0F0F) begin
            miscompares++;
            $display("FAIL latency_E17: out_valid=%b busy=%b in_ready=%b out=%h required 0 0 1 0f0f",
                     out_valid, busy, in_ready, out);
        end
        $display("latency: a=ffff b=0f0f out=%h", out);
    endtask

    task automatic test_stall();
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'hFFFF;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a        = 16'h0000;
        for (int i = 0; i < LAT; i++) step();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out !== 16'h1234 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold%0d: out_valid=%b out=%h in_ready=%b required 1 1234 0",
                         i, out_valid, out, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'h1234) begin
            miscompares++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b out=%h required 0 1 1234",
                     out_valid, in_ready, out);
        end
        $display("stall: a=1234 b=ffff out=%h", out);
    endtask

    task automatic test_async_reset();
        bit seen;
        in_valid  = 1'b1;
        a         = 16'hAAAA;
        b         = 16'hFFFF;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out !== 16'h0000 || busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: out_valid=%b out=%h busy=%b in_ready=%b required 0 0000 0 1",
                     out_valid, out, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL async_no_result: spurious activity after reset, required idle");
        end
        $display("async_reset: out=%h busy=%b", out, busy);
    endtask

    task automatic test_ignore();
        bit ready_seen;
        in_valid  = 1'b1;
        a         = 16'h00FF;
        b         = 16'h0FF0;
        out_ready = 1'b0;
        step();
        a = 16'hFFFF;
        b = 16'hFFFF;
        ready_seen = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (in_ready !== 1'b0) ready_seen = 1'b1;
            step();
        end
        vectors++;
        if (ready_seen || out_valid !== 1'b1 || out !== 16'h00F0) begin
            miscompares++;
            $display("FAIL ignore_first: ready_seen=%b out_valid=%b out=%h required 0 1 00f0",
                     ready_seen, out_valid, out);
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_idle: in_ready=%b required 1", in_ready);
        end
        step();  // second pair accepted here
        in_valid = 1'b0;
        for (int i = 0; i < LAT; i++) step();
        vectors++;
        if (out_valid !== 1'b1 || out !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL ignore_second: out_valid=%b out=%h required 1 ffff", out_valid, out);
        end
        $display("ignore: first=00f0 second out=%h", out);
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] pa [2];
        logic [W-1:0] pb [2];
        logic [W-1:0] exp_out [2];
        int acc_cyc [2];
        int n_acc;
        int n_out;
        pa[0] = 16'hAAAA; pb[0] = 16'h5555; exp_out[0] = 16'h0000;
        pa[1] = 16'hC3C3; pb[1] = 16'hFF00; exp_out[1] = 16'hC300;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        n_acc = 0;
        n_out = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 80 && n_out < 2; t++) begin
            in_valid = (n_acc < 2);
            if (n_acc < 2) begin
                a = pa[n_acc];
                b = pb[n_acc];
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (out !== exp_out[n_out]) begin
                    miscompares++;
                    $display("FAIL b2b_out%0d: out=%h required %h", n_out, out, exp_out[n_out]);
                end
                $display("b2b: result %0d out=%h", n_out, out);
                n_out++;
            end
            if (in_valid && in_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (n_out != 2 || acc_cyc[1] - acc_cyc[0] != 18) begin
            miscompares++;
            $display("FAIL b2b_spacing: results=%0d accept_gap=%0d required 2 18",
                     n_out, acc_cyc[1] - acc_cyc[0]);
        end
    endtask

    // Model: IDLE accepts; 16 edges later the result is offered; DONE waits for out_ready.
    task automatic test_random();
        logic [W-1:0] expq [$];
        int mode;      // 0 idle, 1 computing, 2 offering
        int remain;
        int n_acc;
        int n_res;
        int errs;
        mode  = 0;
        remain = 0;
        n_acc = 0;
        n_res = 0;
        errs  = 0;
        for (int t = 0; t < 60000 && (n_acc < 1000 || mode != 0); t++) begin
            in_valid  = (n_acc < 1000) && ($urandom_range(3) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            out_ready = ($urandom_range(1) != 0);
            vectors++;
            if (in_ready !== (mode == 0) || out_valid !== (mode == 2)) begin
                miscompares++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_proto t=%0d: in_ready=%b out_valid=%b required %b %b",
                             t, in_ready, out_valid, (mode == 0), (mode == 2));
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (expq.size() == 0 || out !== expq[0]) begin
                    miscompares++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL rand_out n=%0d: out=%h required %h", n_res, out,
                                 (expq.size() != 0) ? expq[0] : 16'hxxxx);
                end
                if (expq.size() != 0) void'(expq.pop_front());
                n_res++;
            end
            case (mode)
                0: if (in_valid) begin
                    expq.push_back(a & b);
                    n_acc++;
                    mode = 1;
                    remain = LAT;
                end
                1: begin
                    remain--;
                    if (remain == 0) mode = 2;
                end
                default: if (out_ready) mode = 0;
            endcase
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (n_acc != 1000 || n_res != 1000 || expq.size() != 0) begin
            miscompares++;
            $display("FAIL rand_count: accepted=%0d results=%0d pending=%0d required 1000 1000 0",
                     n_acc, n_res, expq.size());
        end
        $display("random: accepted=%0d results=%0d", n_acc, n_res);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        test_reset();
        test_latency();
        go_idle();
        test_stall();
        go_idle();
        test_async_reset();
        go_idle();
        test_ignore();
        go_idle();
        test_back_to_back();
        go_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
